// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: armed capture sequencer between the ADC deserialiser and the capture FIFO.
// Immediate, rising-threshold and continuous captures with decimation, length limit and backpressure.
module adc_capture_ctrl #(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 24,
   parameter int DEC_W    = 8
) (
   input  logic                         adc_data_clk,
   input  logic                         reset,
   input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
   input  logic                         adc_data_valid,
   input  logic                         locked,
   input  logic                         arm,
   input  logic                         abort,
   input  logic [1:0]                   mode,
   input  logic [2:0]                   trig_ch,
   input  logic signed [SAMPLE_W-1:0]   threshold,
   input  logic [DEC_W-1:0]             decim,
   input  logic [CNT_W-1:0]             capture_len,
   input  logic                         fifo_prog_full,
   input  logic                         fifo_busy,
   output logic [NUM_CH*SAMPLE_W-1:0]   fifo_din,
   output logic                         fifo_wr_en,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic                         lock_err,
   output logic [CNT_W-1:0]             sample_count
);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t                     state, state_nx;
   logic [1:0]                 cfg_mode;
   logic [2:0]                 cfg_ch;
   logic signed [SAMPLE_W-1:0] cfg_thr, prev, ch_s;
   logic [DEC_W-1:0]           cfg_decim, dec_cnt, dec_last;
   logic [CNT_W-1:0]           cfg_len;
   logic                       have_prev, in_run, lock_fail, arm_ok, live, cont;
   logic                       trig, adv, sel, wr, drop, last;
   // Out-of-range trigger channels shift to zero rather than indexing past the bus.
   always_comb begin
      in_run    = state == ARMED || state == CAPTURE;
      lock_fail = in_run && !locked;
      arm_ok    = arm && locked && !abort && (state == IDLE || state == DONE);
      live      = adc_data_valid && in_run && locked && !abort;
      cont      = cfg_mode == 2'd2;
      ch_s      = SAMPLE_W'(adc_data >> (cfg_ch * SAMPLE_W));
      trig      = live && state == ARMED && have_prev && prev < cfg_thr && ch_s >= cfg_thr;
      adv       = live && (state == CAPTURE || trig);
      sel       = adv && dec_cnt == '0;
      wr        = sel && !fifo_prog_full && !fifo_busy;
      drop      = sel && !wr;
      last      = wr && !cont && sample_count + 1'b1 == cfg_len;
      dec_last  = cfg_decim == '0 ? '0 : cfg_decim - 1'b1;
      state_nx  = lock_fail || (in_run && abort) ? IDLE
                : arm_ok ? (mode == 2'd2 ? CAPTURE : capture_len == '0 ? DONE : mode == 2'd1 ? ARMED : CAPTURE)
                : last ? DONE
                : trig ? CAPTURE
                : state;
   end
   always_ff @(posedge adc_data_clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge adc_data_clk) begin
      if (reset) begin
         fifo_din     <= '0;
         fifo_wr_en   <= 1'b0;
         overflow     <= 1'b0;
         lock_err     <= 1'b0;
         sample_count <= '0;
         cfg_mode     <= '0;
         cfg_ch       <= '0;
         cfg_thr      <= '0;
         cfg_decim    <= '0;
         cfg_len      <= '0;
         dec_cnt      <= '0;
         prev         <= '0;
         have_prev    <= 1'b0;
      end else begin
         fifo_wr_en <= wr;
         if (wr) fifo_din <= adc_data;
         if (arm_ok) begin
            cfg_mode     <= mode;
            cfg_ch       <= trig_ch;
            cfg_thr      <= threshold;
            cfg_decim    <= decim;
            cfg_len      <= capture_len;
            sample_count <= '0;
            overflow     <= 1'b0;
            lock_err     <= 1'b0;
            dec_cnt      <= '0;
            have_prev    <= 1'b0;
         end else begin
            if (wr && !(cont && &sample_count)) sample_count <= sample_count + 1'b1;
            if (drop) overflow <= 1'b1;
            if (lock_fail) lock_err <= 1'b1;
            if (adv) dec_cnt <= dec_cnt == dec_last ? '0 : dec_cnt + 1'b1;
            if (live && state == ARMED) begin
               prev      <= ch_s;
               have_prev <= 1'b1;
            end
         end
      end
   end
   assign busy = in_run;
   assign done = state == DONE;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: randomized scoreboard bench for adc_capture_ctrl.
// A sample-list reference model predicts every FIFO write (data and cycle) and the end-of-run status.
module tb_adc_capture_ctrl;
   localparam int NUM_CH = 2, SAMPLE_W = 16, CNT_W = 24, DEC_W = 8, DW = NUM_CH * SAMPLE_W, N = 64;
   logic                       adc_data_clk = 1'b0, reset = 1'b1;
   logic [DW-1:0]              adc_data = '0;
   logic                       adc_data_valid = 1'b0, locked = 1'b1, arm = 1'b0, abort = 1'b0;
   logic [1:0]                 mode = '0;
   logic [2:0]                 trig_ch = '0;
   logic signed [SAMPLE_W-1:0] threshold = '0;
   logic [DEC_W-1:0]           decim = '0;
   logic [CNT_W-1:0]           capture_len = '0;
   logic                       fifo_prog_full = 1'b0, fifo_busy = 1'b0;
   logic [DW-1:0]              fifo_din;
   logic                       fifo_wr_en, busy, done, overflow, lock_err;
   logic [CNT_W-1:0]           sample_count;
   typedef struct {int tk; logic [DW-1:0] d;} wr_t;
   wr_t           exp_q[$];
   logic [DW-1:0] d_data[N];
   bit            d_valid[N], d_pf[N], d_fb[N];
   int            checks = 0, fails = 0, st = 0, mt = 0;
   always #5 adc_data_clk = ~adc_data_clk;
   adc_capture_ctrl #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
      .adc_data_clk(adc_data_clk), .reset(reset), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
      .locked(locked), .arm(arm), .abort(abort), .mode(mode), .trig_ch(trig_ch), .threshold(threshold),
      .decim(decim), .capture_len(capture_len), .fifo_prog_full(fifo_prog_full), .fifo_busy(fifo_busy),
      .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done), .overflow(overflow),
      .lock_err(lock_err), .sample_count(sample_count)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(negedge adc_data_clk);
      st++;
   endtask
   function automatic logic [DW-1:0] word(input int c0, input int c1);
      return {16'(c1), 16'(c0)};
   endfunction
   task automatic fill(input int vp, input int pp, input int fp, input int centre);
      for (int i = 0; i < N; i++) begin
         d_data[i]  = word(centre + int'($urandom_range(40)) - 20, centre + int'($urandom_range(40)) - 20);
         d_valid[i] = $urandom_range(99) < vp;
         d_pf[i]    = $urandom_range(99) < pp;
         d_fb[i]    = $urandom_range(99) < fp;
      end
   endtask
   task automatic check_status(input bit e_done, input int e_cnt, input bit e_ovf, input bit e_busy, input bit e_lock);
      chk("done", done, e_done);
      chk("sample_count", sample_count, e_cnt);
      chk("overflow", overflow, e_ovf);
      chk("busy", busy, e_busy);
      chk("lock_err", lock_err, e_lock);
   endtask
   // Model: walk the valid samples; before the trigger only track prev, afterwards keep every dc-th one.
   task automatic run_cap(input logic [1:0] md, input int ch, input int thr, input int dc, input int len,
                          input int n, output bit fin, output int cnt, output bit ovf);
      int base, k, dk;
      bit started, have_prev;
      logic signed [SAMPLE_W-1:0] s, prev, th;
      wr_t e;
      step();
      mode = md; trig_ch = 3'(ch); threshold = 16'(thr); decim = 8'(dc); capture_len = 24'(len);
      arm = 1'b1; adc_data_valid = 1'b0; fifo_prog_full = 1'b0; fifo_busy = 1'b0;
      step();
      arm = 1'b0; mode = 2'($urandom); trig_ch = 3'($urandom); threshold = 16'($urandom);
      decim = 8'($urandom); capture_len = 24'($urandom);
      base = st + 1;
      th = 16'(thr); dk = dc == 0 ? 1 : dc;
      started = md != 2'd1; have_prev = 1'b0; prev = '0;
      fin = md != 2'd2 && len == 0; k = 0; cnt = 0; ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!d_valid[i] || fin) continue;
         s = d_data[i][ch*SAMPLE_W +: SAMPLE_W];
         if (!started) begin
            if (have_prev && prev < th && s >= th) started = 1'b1;
            else begin
               prev = s;
               have_prev = 1'b1;
               continue;
            end
         end
         if (k % dk == 0) begin
            if (d_pf[i] || d_fb[i]) ovf = 1'b1;
            else begin
               e.tk = base + i + 1; e.d = d_data[i];
               exp_q.push_back(e);
               cnt++;
               if (md != 2'd2 && cnt == len) fin = 1'b1;
            end
         end
         k++;
      end
      for (int i = 0; i < n; i++) begin
         step();
         adc_data = d_data[i]; adc_data_valid = d_valid[i]; fifo_prog_full = d_pf[i]; fifo_busy = d_fb[i];
      end
      step();
      adc_data_valid = 1'b0; fifo_prog_full = 1'b0; fifo_busy = 1'b0;
      step();
      chk("pending_writes", exp_q.size(), 0);
      exp_q.delete();
      check_status(fin, cnt, ovf, !fin, 1'b0);
   endtask
   initial begin
      wr_t e;
      forever begin
         @(negedge adc_data_clk);
         mt++;
         if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_write", fifo_din, 'x);
            else begin
               e = exp_q.pop_front();
               chk("wr_data", fifo_din, e.d);
               chk("wr_cycle", mt, e.tk);
            end
         end
      end
   end
   initial begin
      bit fin, ovf;
      int cnt, thr;
      logic [1:0] md;
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_din", fifo_din, 0);
      check_status(0, 0, 0, 0, 0);
      fill(100, 0, 0, 0);
      run_cap(0, 0, 0, 1, 8, 12, fin, cnt, ovf);
      fill(100, 0, 0, 0);
      for (int i = 0; i < 16; i++) d_data[i] = word(i, i);
      run_cap(0, 0, 0, 4, 3, 16, fin, cnt, ovf);
      fill(100, 0, 0, 50);
      d_data[0] = word(7, 90); d_data[1] = word(8, 95); d_data[2] = word(9, 99);
      d_data[3] = word(10, 100); d_data[4] = word(11, 101); d_data[5] = word(12, 102);
      run_cap(1, 1, 100, 1, 3, 10, fin, cnt, ovf);
      fill(100, 0, 0, 50);
      d_data[0] = word(1, 120); d_data[1] = word(2, 130); d_data[2] = word(3, 110);
      d_data[3] = word(4, 50); d_data[4] = word(5, 150); d_data[5] = word(6, 160);
      run_cap(1, 1, 100, 1, 2, 10, fin, cnt, ovf);
      fill(100, 0, 0, 0);
      d_pf[3] = 1'b1; d_pf[4] = 1'b1; d_pf[5] = 1'b1;
      run_cap(0, 0, 0, 1, 10, 16, fin, cnt, ovf);
      repeat (10) begin
         thr = int'($urandom_range(100)) - 50;
         md = 2'($urandom_range(2));
         if (md == 2'd2) md = 2'd3;
         fill(75, 15, 5, thr);
         run_cap(md, int'($urandom_range(1)), thr, int'($urandom_range(3)), int'($urandom_range(6)), 40, fin, cnt, ovf);
         if (!fin) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            step();
         end
      end
      fill(100, 0, 0, 0);
      d_pf[8] = 1'b1;
      run_cap(2, 0, 0, 2, 3, 20, fin, cnt, ovf);
      step();
      abort = 1'b1; arm = 1'b1; mode = 2'd0; capture_len = 24'd5;
      step();
      abort = 1'b0; arm = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         adc_data = $urandom; adc_data_valid = 1'b1;
      end
      step();
      adc_data_valid = 1'b0;
      step();
      check_status(0, cnt, ovf, 0, 0);
      fill(100, 0, 0, 0);
      run_cap(0, 0, 0, 1, 0, 3, fin, cnt, ovf);
      fill(100, 0, 0, 0);
      run_cap(0, 0, 0, 1, 20, 5, fin, cnt, ovf);
      step();
      locked = 1'b0; adc_data_valid = 1'b1;
      repeat (3) begin
         step();
         adc_data = $urandom;
      end
      step();
      adc_data_valid = 1'b0;
      step();
      check_status(0, cnt, 0, 0, 1);
      step();
      arm = 1'b1; mode = 2'd0; capture_len = 24'd3;
      step();
      arm = 1'b0; adc_data_valid = 1'b1;
      repeat (3) step();
      adc_data_valid = 1'b0;
      step();
      check_status(0, cnt, 0, 0, 1);
      locked = 1'b1;
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Parametrised capture sequencer for the SYZYGY ADC path. It sits between the ADC deserialiser outputs and the async capture FIFO, and runs entirely in the adc_data_clk domain. It replaces the fixed fill-while-triggered write-enable logic with armed captures: immediate, threshold-triggered or continuous, with decimation, a sample count limit, backpressure handling and status reporting.

Parameters:
NUM_CH, 2, number of ADC channels packed per FIFO word (1..8)
SAMPLE_W, 16, bits per channel sample
CNT_W, 24, width of capture length and sample counter
DEC_W, 8, width of decimation factor

Ports:
adc_data_clk  in  1  capture clock; all logic on rising edge
reset  in  1  synchronous, active-high
adc_data  in  NUM_CH*SAMPLE_W  channel samples; ch0 in LSBs
adc_data_valid  in  1  sample qualifier (bitslip aligned)
locked  in  1  clocking/IDELAY ready
arm  in  1  single-cycle start pulse
abort  in  1  single-cycle stop pulse
mode  in  2  0=immediate, 1=rising threshold, 2=continuous, 3=reserved (treated as 0)
trig_ch  in  3  channel index compared in mode 1
threshold  in  SAMPLE_W  signed (two's complement) trigger level
decim  in  DEC_W  keep 1 of every decim samples; 0 is treated as 1
capture_len  in  CNT_W  samples to write (modes 0/1)
fifo_prog_full  in  1  FIFO backpressure
fifo_busy  in  1  FIFO reset in progress
fifo_din  out  NUM_CH*SAMPLE_W  registered write data
fifo_wr_en  out  1  registered write strobe
busy  out  1  high in ARMED or CAPTURE
done  out  1  level; capture completed
overflow  out  1  sticky; a selected sample was dropped
lock_err  out  1  sticky; locked fell while busy
sample_count  out  CNT_W  samples written this capture

Behaviour:
- Reset: state IDLE. All outputs are 0; decimation counter, previous-sample register and config latches are cleared.
- Config latch: mode, trig_ch, threshold, decim and capture_len are latched on an accepted arm. Later input changes have no effect until the next arm.
- An arm is accepted only in IDLE or DONE, and only with locked=1. An accepted arm clears done, overflow, lock_err and sample_count, and resets the decimation phase. An arm while busy is ignored.
- States:
  - IDLE: wait for an accepted arm. Mode 0/2 goes to CAPTURE; mode 1 goes to ARMED. In mode 0/1, capture_len==0 goes directly to DONE with no writes.
  - ARMED: on each valid sample, compare s = adc_data[trig_ch]. Trigger when prev < threshold and s >= threshold (signed). prev is the previous valid sample of that channel; the first valid sample after arm only loads prev and never triggers. The triggering sample is the first selected sample; it is written the same way as in CAPTURE, then the state moves to CAPTURE.
  - CAPTURE: each valid sample advances the decimation counter. The sample at phase 0 is selected, so the first valid sample is always selected.
    - Selected, with !fifo_prog_full and !fifo_busy: fifo_din is set to adc_data, fifo_wr_en=1 on the next cycle, and sample_count increments.
    - Selected while prog_full or fifo_busy: the sample is dropped, overflow=1, and sample_count does not advance.
    - Mode 0/1: when sample_count reaches capture_len (registered on the cycle of the last write), go to DONE and set done=1.
    - Mode 2: never completes; sample_count saturates at all-ones.
  - DONE: done held at 1 until the next accepted arm.
- Abort in ARMED or CAPTURE returns to IDLE with done=0; counts and flags are held. Abort has priority over arm and over trigger in the same cycle.
- locked=0 while busy: go to IDLE, lock_err=1, no further writes.
- Latency: adc_data to fifo_din/fifo_wr_en is exactly 1 cycle. fifo_wr_en is never high for more than one cycle per valid sample.
- Non-valid cycles: no counter, decimation or trigger updates.
- The reset synchroniser for reset is external; there are no CDC crossings inside the block.

Test Plan:
- Mode 0, NUM_CH=2, capture_len=8, decim=1, continuous valid: arm -> 8 consecutive wr_en pulses starting 1 cycle after the first valid, fifo_din matches the input, done=1, sample_count=8.
- Mode 0, decim=4, capture_len=3, valid every cycle, inputs 0..15 -> samples 0, 4, 8 written, then done.
- Mode 1, threshold=100, trig_ch=1, ch1 ramp 90,95,99,100,101 -> first write carries 100, then capture_len samples in total. An arm whose first sample is already 120 causes no trigger until a fresh crossing.
- Mode 0, capture_len=10, prog_full asserted for 3 selected samples mid-run -> 3 samples dropped, overflow=1, exactly 10 writes total, done=1.
- Mode 2 run, then abort and arm in the same cycle -> IDLE, done=0, no further writes. A second arm then clears overflow and sample_count.
- Drop locked during CAPTURE -> wr_en stays 0 from the next cycle, lock_err=1, busy=0. An arm with locked=0 is ignored.
